// File: rtl/emif_calbus_initiator.sv
// rtl/emif_calbus_initiator.sv - single-outstanding calbus master (read / write / masked RMW)
// Optional address range check enabled by defining CALBUS_ADDR_CHECK_EN.
module emif_calbus_initiator #(
  parameter int          RD_LATENCY = 2,
  parameter int          GAP        = 1,
  parameter logic [19:0] ADDR_LIMIT = 20'hFFFFF
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [19:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_mask,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        calbus_read,
  output logic        calbus_write,
  output logic [19:0] calbus_address,
  output logic [31:0] calbus_wdata,
  input  logic [31:0] calbus_rdata
);

  typedef enum logic [2:0] {IDLE, RD_STB, RD_WAIT, WR_STB, RESP, GAP_WAIT} state_t;

  localparam logic [2:0] RD_LAT = 3'(RD_LATENCY);
  localparam logic [3:0] GAP_N  = 4'(GAP);
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_RMW = 2'b10;

  state_t      state;
  logic [1:0]  op_q;
  logic [31:0] wdata_q;
  logic [31:0] mask_q;
  logic [31:0] old_q;
  logic [2:0]  rd_cnt;
  logic [3:0]  gap_cnt;
  logic        addr_bad;

`ifdef CALBUS_ADDR_CHECK_EN
  assign addr_bad = (req_addr > ADDR_LIMIT);
`else
  logic unused_addr_limit;
  assign unused_addr_limit = ^ADDR_LIMIT;
  assign addr_bad = 1'b0;
`endif

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state          <= IDLE;
      req_ready      <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
      rsp_err        <= 1'b0;
      calbus_read    <= 1'b0;
      calbus_write   <= 1'b0;
      calbus_address <= '0;
      calbus_wdata   <= '0;
      op_q           <= '0;
      wdata_q        <= '0;
      mask_q         <= '0;
      old_q          <= '0;
      rd_cnt         <= '0;
      gap_cnt        <= '0;
    end else begin
      calbus_read  <= 1'b0;
      calbus_write <= 1'b0;
      rsp_valid    <= 1'b0;
      case (state)
        IDLE: begin
          if (!req_ready) begin
            req_ready <= 1'b1;
          end else if (req_valid) begin
            req_ready      <= 1'b0;
            op_q           <= req_op;
            wdata_q        <= req_wdata;
            mask_q         <= req_mask;
            calbus_address <= req_addr;
            if (addr_bad) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else if (req_op == OP_WR) begin
              state        <= WR_STB;
              calbus_write <= 1'b1;
              calbus_wdata <= req_wdata;
            end else begin
              state       <= RD_STB;
              calbus_read <= 1'b1;
            end
          end
        end
        RD_STB: begin
          state  <= RD_WAIT;
          rd_cnt <= 3'd1;
        end
        RD_WAIT: begin
          if (rd_cnt == RD_LAT) begin
            old_q <= calbus_rdata;
            if (op_q == OP_RMW) begin
              state        <= WR_STB;
              calbus_write <= 1'b1;
              calbus_wdata <= (calbus_rdata & ~mask_q) | (wdata_q & mask_q);
            end else begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_rdata <= calbus_rdata;
            end
          end else begin
            rd_cnt <= rd_cnt + 3'd1;
          end
        end
        WR_STB: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= (op_q == OP_RMW) ? old_q : 32'h0;
        end
        RESP: begin
          if (GAP_N == 4'd0) begin
            state     <= IDLE;
            req_ready <= 1'b1;
          end else begin
            state   <= GAP_WAIT;
            gap_cnt <= 4'd1;
          end
        end
        GAP_WAIT: begin
          if (gap_cnt == GAP_N) begin
            state     <= IDLE;
            req_ready <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_emif_calbus_initiator.sv
// tb/tb_emif_calbus_initiator.sv - randomized bench with a cycle-timeline model and a calbus slave memory
module tb_emif_calbus_initiator;

  localparam int          L     = 2;
  localparam int          G     = 1;
  localparam logic [19:0] LIMIT = 20'h0FFFF;
`ifdef CALBUS_ADDR_CHECK_EN
  localparam bit CHECK_ON = 1'b1;
`else
  localparam bit CHECK_ON = 1'b0;
`endif

  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = '0;
  logic [19:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [31:0] req_mask = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        calbus_read;
  logic        calbus_write;
  logic [19:0] calbus_address;
  logic [31:0] calbus_wdata;
  logic [31:0] calbus_rdata = '0;

  emif_calbus_initiator #(.RD_LATENCY(L), .GAP(G), .ADDR_LIMIT(LIMIT)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_mask(req_mask),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .calbus_read(calbus_read), .calbus_write(calbus_write), .calbus_address(calbus_address),
    .calbus_wdata(calbus_wdata), .calbus_rdata(calbus_rdata)
  );

  always #5 clk_clk = ~clk_clk;

  int cyc = 0;
  always @(posedge clk_clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  logic [31:0] mem [logic [19:0]];
  int last_wr_cyc = 0;
  int last_wait = 0;
  int last_rsp_k = 0;
  int last_ready_k = 0;
  logic [31:0] last_wr_data = '0;
  logic [31:0] last_rsp_data = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [19:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[11:0], a} ^ 32'h5A5A_0000;
  endfunction

  // Bitwise merge: each set mask bit takes the new bit, else the old bit survives.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [31:0] mk);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = mk[i] ? nw[i] : old[i];
    return r;
  endfunction

  task automatic run_txn(input logic [1:0] op, input logic [19:0] addr, input logic [31:0] wd,
                         input logic [31:0] mk, input bit hold);
    int wait_n, rd_k, rd_n, wr_k, wr_n, both_n, adr_n, rsp_n, rsp_k, ready_k;
    int exp_rsp, exp_rd_n, exp_wr_n, exp_wr_k;
    logic [31:0] old, wr_d, rsp_d, exp_data, exp_wd;
    logic rsp_e;
    bit err, is_wr, is_rmw;
    err    = CHECK_ON && (addr > LIMIT);
    is_wr  = (op == 2'b01);
    is_rmw = (op == 2'b10);
    old    = mem_rd(addr);
    exp_rd_n = (!err && !is_wr) ? 1 : 0;
    exp_wr_n = (!err && (is_wr || is_rmw)) ? 1 : 0;
    exp_wr_k = (exp_wr_n == 0) ? 0 : (is_wr ? 1 : 2 + L);
    exp_rsp  = err ? 1 : (is_wr ? 2 : (is_rmw ? 3 + L : 2 + L));
    exp_data = (err || is_wr) ? 32'h0 : old;
    exp_wd   = is_wr ? wd : merge(old, wd, mk);

    req_op = op; req_addr = addr; req_wdata = wd; req_mask = mk; req_valid = 1'b1;
    wait_n = 0;
    while (!req_ready && wait_n < 50) begin
      @(negedge clk_clk);
      wait_n++;
    end
    last_wait = wait_n;
    check_eq("accept_bound", 32'(req_ready), 1);
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    @(posedge clk_clk);
    #1;
    if (!hold) req_valid = 1'b0;

    rd_k = 0; rd_n = 0; wr_k = 0; wr_n = 0; both_n = 0; adr_n = 0; rsp_n = 0;
    rsp_k = 0; ready_k = 0; wr_d = '0; rsp_d = '0; rsp_e = 1'b0;
    for (int k = 1; k <= 40 && ready_k == 0; k++) begin
      @(negedge clk_clk);
      if (calbus_read) begin rd_n++; rd_k = k; end
      if (calbus_write) begin wr_n++; wr_k = k; wr_d = calbus_wdata; last_wr_cyc = cyc; end
      if (calbus_read && calbus_write) both_n++;
      if ((calbus_read || calbus_write || rsp_valid) && calbus_address != addr) adr_n++;
      if (rsp_valid) begin rsp_n++; rsp_k = k; rsp_d = rsp_rdata; rsp_e = rsp_err; end
      if (req_ready) ready_k = k;
      calbus_rdata = (rd_k != 0 && k == rd_k + L) ? old : $urandom;
    end

    check_eq("rsp_count", rsp_n, 1);
    check_eq("rsp_cycle", rsp_k, exp_rsp);
    check_eq("rsp_rdata", rsp_d, exp_data);
    check_eq("rsp_err", 32'(rsp_e), 32'(err));
    check_eq("rd_count", rd_n, exp_rd_n);
    check_eq("rd_cycle", rd_k, exp_rd_n);
    check_eq("wr_count", wr_n, exp_wr_n);
    check_eq("wr_cycle", wr_k, exp_wr_k);
    if (exp_wr_n != 0) check_eq("wr_data", wr_d, exp_wd);
    check_eq("strobe_overlap", both_n, 0);
    check_eq("addr_stable", adr_n, 0);
    check_eq("ready_cycle", ready_k, exp_rsp + 1 + G);
    check_eq("rsp_hold", rsp_rdata, exp_data);
    if (exp_wr_n != 0) mem[addr] = exp_wd;
    last_rsp_k = rsp_k; last_ready_k = ready_k; last_wr_data = wr_d; last_rsp_data = rsp_d;
  endtask

  task automatic reset_mid(input int at_k);
    int wait_n, evt_n;
    req_op = 2'b00; req_addr = 20'h00250; req_valid = 1'b1;
    wait_n = 0;
    while (!req_ready && wait_n < 50) begin
      @(negedge clk_clk);
      wait_n++;
    end
    check_eq("rst_accept_bound", 32'(req_ready), 1);
    @(posedge clk_clk);
    #1;
    req_valid = 1'b0;
    repeat (at_k) @(negedge clk_clk);
    #2;
    reset_reset_n = 1'b0;
    #1;
    check_eq("rst_async_clear", 32'({calbus_read, calbus_write, rsp_valid, req_ready, calbus_address}), 0);
    @(negedge clk_clk);
    reset_reset_n = 1'b1;
    evt_n = 0;
    repeat (12) begin
      @(negedge clk_clk);
      if (rsp_valid || calbus_read || calbus_write) evt_n++;
    end
    check_eq("rst_no_late_events", evt_n, 0);
  endtask

  initial begin
    logic [19:0] pool [6];
    int w1;
    pool = '{20'h00040, 20'h00100, 20'h00A00, 20'h0FFFF, 20'h10000, 20'hFFFFF};

    repeat (3) @(negedge clk_clk);
    check_eq("reset_outputs", 32'({req_ready, rsp_valid, rsp_err, calbus_read, calbus_write,
                                   calbus_address}), 0);
    check_eq("reset_data", rsp_rdata | calbus_wdata, 0);
    reset_reset_n = 1'b1;

    mem[20'h00040] = 32'hDEADBEEF;
    run_txn(2'b00, 20'h00040, 32'h0, 32'h0, 1'b0);
    check_eq("plan_read_rdata", last_rsp_data, 32'hDEADBEEF);
    check_eq("plan_read_rsp_cyc", last_rsp_k, 4);
    check_eq("plan_read_ready_cyc", last_ready_k, 6);

    run_txn(2'b01, 20'h00100, 32'h12345678, 32'h0, 1'b0);
    check_eq("plan_write_data", last_wr_data, 32'h12345678);

    mem[20'h00300] = 32'hFFFF0000;
    run_txn(2'b10, 20'h00300, 32'h0000AAAA, 32'h000000FF, 1'b0);
    check_eq("plan_rmw_wdata", last_wr_data, 32'hFFFF00AA);
    check_eq("plan_rmw_rdata", last_rsp_data, 32'hFFFF0000);
    check_eq("plan_rmw_rsp_cyc", last_rsp_k, 5);

    run_txn(2'b01, 20'h00500, 32'hCAFE0001, 32'h0, 1'b1);
    w1 = last_wr_cyc;
    run_txn(2'b01, 20'h00504, 32'hCAFE0002, 32'h0, 1'b0);
    check_eq("b2b_accept_wait", last_wait, 0);
    check_eq("b2b_wr_spacing", last_wr_cyc - w1, 3 + G);

    reset_mid(2);
    run_txn(2'b00, 20'h00040, 32'h0, 32'h0, 1'b0);
    reset_mid(1);
    run_txn(2'b11, 20'h00300, 32'h0, 32'h0, 1'b0);

    run_txn(2'b00, 20'h10000, 32'h0, 32'h0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      run_txn(2'($urandom_range(0, 3)), pool[$urandom_range(0, 5)], $urandom, $urandom,
              1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
